// File: rtl/control_sequencer_if.sv
// control_sequencer_if: groups the instruction, memory handshake, halt request
// and every control strobe exchanged between the control sequencer and the
// datapath.
//   master : the sequencer side (reads IR/mem_ready/stop, drives all strobes)
//   slave  : the datapath side (drives IR/mem_ready/stop, reads all strobes)
interface control_sequencer_if;
  logic [31:0] IR;
  logic        mem_ready;
  logic        stop;

  // Bus drive enables
  logic        PCout;
  logic        ZMuxOut;
  logic        MDRout;
  logic        Cout;
  // Register load enables
  logic        MARin;
  logic        PCin;
  logic        MDRin;
  logic        IRin;
  logic        Yin;
  logic        HIin;
  logic        LOin;
  // Miscellaneous controls
  logic        IncPC;
  logic        Read;
  logic        ALUin;
  logic        ZMuxEnbale;
  logic        ZSelect;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic [4:0]  aluControl;
  logic [31:0] C_sext;
  logic        run;
  logic        illegal;

  modport master (
    input  IR, mem_ready, stop,
    output PCout, ZMuxOut, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, HIin, LOin,
           IncPC, Read, ALUin, ZMuxEnbale, ZSelect, Rout, Rin, aluControl, C_sext,
           run, illegal
  );

  modport slave (
    output IR, mem_ready, stop,
    input  PCout, ZMuxOut, MDRout, Cout, MARin, PCin, MDRin, IRin, Yin, HIin, LOin,
           IncPC, Read, ALUin, ZMuxEnbale, ZSelect, Rout, Rin, aluControl, C_sext,
           run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit. Steps each instruction
// through fetch (T0-T2), operand read (T3), ALU operation (T4) and writeback
// (T5, plus T6 for the high word of mul/div), and drives the datapath strobes.
// Ports:
//   clock : sole clock, rising edge
//   clear : asynchronous active-high reset; forces RST and all strobes low
//   bus   : control_sequencer_if.master -- IR, mem_ready, stop in; strobes,
//           register selects, aluControl, C_sext, run and illegal out
module control_sequencer (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_t;

  state_t stateQ, stateD;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       isRType, isImm, isMulDiv, isNop, isHalt;

  assign opcode   = bus.IR[31:27];
  assign ra       = bus.IR[26:23];
  assign rb       = bus.IR[22:19];
  assign rc       = bus.IR[18:15];

  assign isRType  = (opcode <= 5'd8);
  assign isImm    = (opcode == 5'd12) || (opcode == 5'd13) || (opcode == 5'd14);
  assign isMulDiv = (opcode == 5'd15) || (opcode == 5'd16);
  assign isNop    = (opcode == 5'd26);
  assign isHalt   = (opcode == 5'd27);

  // Immediate field is always available to the datapath, independent of state.
  assign bus.C_sext = {{13{bus.IR[18]}}, bus.IR[18:0]};

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      stateQ <= StRst;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD         = stateQ;
    bus.PCout      = 1'b0;
    bus.ZMuxOut    = 1'b0;
    bus.MDRout     = 1'b0;
    bus.Cout       = 1'b0;
    bus.MARin      = 1'b0;
    bus.PCin       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.HIin       = 1'b0;
    bus.LOin       = 1'b0;
    bus.IncPC      = 1'b0;
    bus.Read       = 1'b0;
    bus.ALUin      = 1'b0;
    bus.ZMuxEnbale = 1'b0;
    bus.ZSelect    = 1'b0;
    bus.Rout       = 16'h0000;
    bus.Rin        = 16'h0000;
    bus.aluControl = 5'b00000;
    bus.run        = 1'b0;
    bus.illegal    = 1'b0;

    unique case (stateQ)
      StRst: begin
        stateD = StT0;
      end
      StT0: begin
        bus.run   = 1'b1;
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.ALUin = 1'b1;
        stateD    = StT1;
      end
      StT1: begin
        bus.run        = 1'b1;
        bus.ZMuxEnbale = 1'b1;
        bus.ZMuxOut    = 1'b1;
        bus.Read       = 1'b1;
        // Loads gated by mem_ready so a stall never reloads PC or MDR.
        bus.PCin       = bus.mem_ready;
        bus.MDRin      = bus.mem_ready;
        if (bus.mem_ready) begin
          stateD = StT2;
        end
      end
      StT2: begin
        bus.run    = 1'b1;
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        stateD     = StT3;
      end
      StT3: begin
        bus.run  = 1'b1;
        bus.Rout = 16'h0001 << rb;
        bus.Yin  = 1'b1;
        if (isRType || isImm || isMulDiv) begin
          stateD = StT4;
        end else if (isHalt) begin
          stateD = StHalt;
        end else begin
          bus.illegal = !isNop;
          stateD      = StT0;
        end
      end
      StT4: begin
        bus.run   = 1'b1;
        bus.ALUin = 1'b1;
        if (isImm) begin
          bus.Cout = 1'b1;
          unique case (opcode)
            5'd13:   bus.aluControl = 5'b00010;
            5'd14:   bus.aluControl = 5'b00011;
            default: bus.aluControl = 5'b00000;
          endcase
        end else begin
          bus.Rout       = 16'h0001 << rc;
          bus.aluControl = opcode;
        end
        stateD = StT5;
      end
      StT5: begin
        bus.run        = 1'b1;
        bus.ZMuxEnbale = 1'b1;
        bus.ZMuxOut    = 1'b1;
        if (isMulDiv) begin
          bus.LOin = 1'b1;
          stateD   = StT6;
        end else begin
          bus.Rin = 16'h0001 << ra;
          stateD  = bus.stop ? StHalt : StT0;
        end
      end
      StT6: begin
        bus.run        = 1'b1;
        bus.ZMuxEnbale = 1'b1;
        bus.ZMuxOut    = 1'b1;
        bus.ZSelect    = 1'b1;
        bus.HIin       = 1'b1;
        stateD         = bus.stop ? StHalt : StT0;
      end
      StHalt: begin
        stateD = StHalt;
      end
      default: begin
        stateD = StRst;
      end
    endcase
  end

endmodule
